// File: rtl/cmn_entry_alloc_ctrl_if.sv
// rtl/cmn_entry_alloc_ctrl_if.sv - allocation, release and status bundle for the entry pool controller
interface cmn_entry_alloc_ctrl_if #(
    parameter int ENTRY_NUM = 16
);
    localparam int AWIDTH = $clog2(ENTRY_NUM);

    logic                  alloc_req;
    logic                  alloc_gnt;
    logic [ENTRY_NUM-1:0]  v_alloc_idx_oh;
    logic [AWIDTH-1:0]     v_alloc_idx_bin;
    logic                  rel_vld;
    logic [ENTRY_NUM-1:0]  v_rel_mask;
    logic                  flush;
    logic [ENTRY_NUM-1:0]  v_busy;
    logic [AWIDTH:0]       busy_cnt;
    logic                  full;
    logic                  empty;
    logic                  rel_err;

    // Requester side: issues alloc/release/flush, observes grant and pool status
    modport master (
        output alloc_req, rel_vld, v_rel_mask, flush,
        input  alloc_gnt, v_alloc_idx_oh, v_alloc_idx_bin,
               v_busy, busy_cnt, full, empty, rel_err
    );

    // Controller side
    modport slave (
        input  alloc_req, rel_vld, v_rel_mask, flush,
        output alloc_gnt, v_alloc_idx_oh, v_alloc_idx_bin,
               v_busy, busy_cnt, full, empty, rel_err
    );
endinterface

// File: rtl/cmn_entry_alloc_ctrl.sv
// rtl/cmn_entry_alloc_ctrl.sv - entry pool allocator with MSB-first selection, multi-hot release and flush
module cmn_entry_alloc_ctrl #(
    parameter int ENTRY_NUM = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    cmn_entry_alloc_ctrl_if.slave  bus
);
    localparam int              AWIDTH   = $clog2(ENTRY_NUM);
    localparam logic [AWIDTH:0] FULL_CNT = (AWIDTH+1)'(ENTRY_NUM);

    logic [ENTRY_NUM-1:0] busy;
    logic [AWIDTH:0]      cnt;
    logic                 err;

    logic [ENTRY_NUM-1:0] sel_oh;
    logic [AWIDTH-1:0]    sel_bin;
    logic                 full_w;
    logic                 gnt;
    logic [ENTRY_NUM-1:0] rel_eff;
    logic                 rel_illegal;
    logic [AWIDTH:0]      rel_cnt;
    logic [AWIDTH:0]      cnt_next;

    assign full_w = (cnt == FULL_CNT);

    // Pick the highest-index free entry; later (higher) hits overwrite earlier ones
    always_comb begin
        sel_oh  = '0;
        sel_bin = '0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            if (!busy[i]) begin
                sel_oh    = '0;
                sel_oh[i] = 1'b1;
                sel_bin   = AWIDTH'(i);
            end
        end
    end

    // Grant is purely combinational; a non-full pool always has a free entry to select
    assign gnt = bus.alloc_req && !full_w && !bus.flush && !rst;

    // Only entries that are actually busy are released; other mask bits flag an error
    assign rel_eff     = bus.v_rel_mask & busy & {ENTRY_NUM{bus.rel_vld}};
    assign rel_illegal = bus.rel_vld && (|(bus.v_rel_mask & ~busy));

    // Count the entries really freed this cycle
    always_comb begin
        rel_cnt = '0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            rel_cnt = rel_cnt + {{AWIDTH{1'b0}}, rel_eff[i]};
        end
    end

    assign cnt_next = cnt + {{AWIDTH{1'b0}}, gnt} - rel_cnt;

    // Pool state: reset and flush clear everything, otherwise release then set the granted entry
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            busy <= '0;
            cnt  <= '0;
            err  <= 1'b0;
        end else begin
            busy <= (busy & ~rel_eff) | (gnt ? sel_oh : '0);
            cnt  <= cnt_next;
            if (rel_illegal) begin
                err <= 1'b1;
            end
        end
    end

    assign bus.alloc_gnt       = gnt;
    assign bus.v_alloc_idx_oh  = gnt ? sel_oh  : '0;
    assign bus.v_alloc_idx_bin = gnt ? sel_bin : '0;
    assign bus.v_busy          = busy;
    assign bus.busy_cnt        = cnt;
    assign bus.full            = full_w;
    assign bus.empty           = (cnt == '0);
    assign bus.rel_err         = err;
endmodule

// File: doc/cmn_entry_alloc_ctrl.md
CMN_ENTRY_ALLOC_CTRL -- requirements
Module: cmn_entry_alloc_ctrl

Interface
REQ-001 The block SHALL have parameter ENTRY_NUM, default 16, giving the number of pool entries; legal values are powers of two from 2 to 64.
REQ-002 The block SHALL have localparam AWIDTH = $clog2(ENTRY_NUM), giving the entry index width.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset; the ports are named clk and rst.
REQ-004 Port clk: input, 1 bit, clock; all state updates occur on the rising edge.
REQ-005 Port rst: input, 1 bit, synchronous active-high reset.
REQ-006 Port alloc_req: input, 1 bit, requests one entry this cycle.
REQ-007 Port alloc_gnt: output, 1 bit, indicates the allocation is granted this cycle.
REQ-008 Port v_alloc_idx_oh: output, ENTRY_NUM bits, one-hot granted entry.
REQ-009 Port v_alloc_idx_bin: output, AWIDTH bits, binary index of the granted entry.
REQ-010 Port rel_vld: input, 1 bit, qualifies v_rel_mask.
REQ-011 Port v_rel_mask: input, ENTRY_NUM bits, entries to release (multi-hot allowed).
REQ-012 Port flush: input, 1 bit, releases all entries.
REQ-013 Port v_busy: output, ENTRY_NUM bits, registered busy vector.
REQ-014 Port busy_cnt: output, AWIDTH+1 bits, registered count of busy entries.
REQ-015 Port full: output, 1 bit, all entries busy (registered-derived).
REQ-016 Port empty: output, 1 bit, no entry busy (registered-derived).
REQ-017 Port rel_err: output, 1 bit, sticky flag for an illegal release.

Function
REQ-018 The block SHALL hold state in the registers busy[ENTRY_NUM-1:0], cnt[AWIDTH:0] and err; v_busy = busy, busy_cnt = cnt, rel_err = err.
REQ-019 Selection SHALL pick the highest-index entry with busy = 0 (MSB-first leading-one of ~busy), computed combinationally from the current busy register only.
REQ-020 alloc_gnt SHALL equal alloc_req && !full && !flush && !rst, with zero-cycle latency from alloc_req.
REQ-021 v_alloc_idx_oh and v_alloc_idx_bin SHALL show the selected entry whenever alloc_gnt = 1, and SHALL be all zeros when alloc_gnt = 0.
REQ-022 On a grant, busy[sel] SHALL be set at the next rising edge, so the entry is busy one cycle after the grant.
REQ-023 Releases SHALL apply only when rel_vld = 1: busy &= ~v_rel_mask at the next edge.
REQ-024 There SHALL be no release-to-alloc bypass: an entry released in cycle N is first allocatable in cycle N+1.
REQ-025 Allocation and release in the same cycle SHALL both take effect; no conflict is possible because the selected entry is free.
REQ-026 If rel_vld = 1 and (v_rel_mask & ~busy) != 0, err SHALL set at the next edge; the legal bits are still released and the illegal bits are ignored.
REQ-027 err SHALL stay set until rst or flush.
REQ-028 cnt_next SHALL equal cnt + alloc_gnt - popcount(v_rel_mask & busy & {ENTRY_NUM{rel_vld}}); it never wraps and always equals popcount(busy).
REQ-029 full SHALL equal (cnt == ENTRY_NUM); empty SHALL equal (cnt == 0); both are derived only from registers.
REQ-030 flush SHALL take priority over alloc and release: at the next edge busy = 0, cnt = 0 and err = 0, and alloc_gnt = 0 in the flush cycle.
REQ-031 When full, alloc_req SHALL be held off (alloc_gnt = 0); a release that same cycle makes an entry available in the next cycle.
REQ-032 The block SHALL grant at most one allocation per cycle.

Reset
REQ-033 On rst = 1 at a rising edge: busy = 0, cnt = 0, err = 0.
REQ-034 During any cycle with rst = 1: alloc_gnt = 0 and the index outputs are 0, regardless of alloc_req.
REQ-035 After reset: empty = 1, full = 0.
REQ-036 Reset asserted in the middle of an allocation discards any grant pending in that cycle; no entry is marked busy.
REQ-037 The first grant after reset deassertion SHALL return index ENTRY_NUM-1.

Verification
REQ-038 Scenario (ENTRY_NUM=16): reset, then alloc_req held for 17 cycles -> grants of idx 15,14,...,0 in cycles 1-16; cycle 17 gives alloc_gnt = 0, full = 1, busy_cnt = 16.
REQ-039 Scenario: when full, release with v_rel_mask = 0x0120 while alloc_req = 1 -> no grant in that cycle; next cycle grants idx 8, then idx 5; busy_cnt goes 14 -> 15 -> 16.
REQ-040 Scenario: busy = 0x8000, then same cycle alloc_req = 1 and release 0x8000 -> grant idx 14; next-cycle busy = 0x4000, busy_cnt = 1.
REQ-041 Scenario: busy = 0x000F, release 0x0030 -> rel_err = 1 the next cycle, busy unchanged, busy_cnt = 4; then flush -> busy = 0, rel_err = 0, empty = 1.
REQ-042 Scenario: flush and alloc_req in the same cycle with busy = 0x00FF -> alloc_gnt = 0, and the next cycle busy = 0.
REQ-043 Scenario: rst asserted while alloc_req = 1 with busy = 0x0F0F -> alloc_gnt = 0, and the next cycle busy = 0, busy_cnt = 0.
